// File: rtl/regstore.sv
// 32 x 32-bit architectural register file with a hardwired-zero register 31 and a busy scoreboard.
// Optional REGSTORE_BYPASS_EN suppresses hazards that the same-cycle write-back will resolve.
module regstore (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [4:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic        iss_en,
    input  logic [4:0]  iss_sel,
    input  logic [4:0]  rd_sel_a,
    input  logic [4:0]  rd_sel_b,
    output logic [31:0] regs [31:0],
    output logic [31:0] busy,
    output logic        hazard_a,
    output logic        hazard_b
);

    logic [30:0] w_wr_dec;
    logic [30:0] w_iss_dec;
    logic        w_byp_a;
    logic        w_byp_b;

    // Decoders cover 0..30 only, so a select of 31 enables nothing.
    always_comb begin
        w_wr_dec  = '0;
        w_iss_dec = '0;
        for (int i = 0; i < 31; i++) begin
            w_wr_dec[i]  = wr_en  && (wr_sel  == 5'(i));
            w_iss_dec[i] = iss_en && (iss_sel == 5'(i));
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 31; gi++) begin : g_reg
            logic [31:0] r_data;
            logic        r_busy;

            // An issue on the same edge as a write-back wins: the new producer owns the register.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_data <= '0;
                    r_busy <= 1'b0;
                end else begin
                    if (w_wr_dec[gi]) begin
                        r_data <= wr_data;
                    end
                    if (w_iss_dec[gi]) begin
                        r_busy <= 1'b1;
                    end else if (w_wr_dec[gi]) begin
                        r_busy <= 1'b0;
                    end
                end
            end

            assign regs[gi] = r_data;
            assign busy[gi] = r_busy;
        end
    endgenerate

    assign regs[31] = '0;
    assign busy[31] = 1'b0;

`ifdef REGSTORE_BYPASS_EN
    assign w_byp_a = wr_en && (wr_sel == rd_sel_a) && !(iss_en && (iss_sel == rd_sel_a));
    assign w_byp_b = wr_en && (wr_sel == rd_sel_b) && !(iss_en && (iss_sel == rd_sel_b));
`else
    assign w_byp_a = 1'b0;
    assign w_byp_b = 1'b0;
`endif

    assign hazard_a = busy[rd_sel_a] && !w_byp_a;
    assign hazard_b = busy[rd_sel_b] && !w_byp_b;

endmodule

// File: tb/tb_regstore.sv
// Self-checking bench for regstore: per-cycle comparison against a rule-level model
// plus directed literal checks; honours REGSTORE_BYPASS_EN when defined.
module tb_regstore;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_sel = '0;
    logic [31:0] wr_data = '0;
    logic        iss_en = 1'b0;
    logic [4:0]  iss_sel = '0;
    logic [4:0]  rd_sel_a = '0;
    logic [4:0]  rd_sel_b = '0;
    logic [31:0] regs [31:0];
    logic [31:0] busy;
    logic        hazard_a;
    logic        hazard_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    always #5 clk = ~clk;

    regstore dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_sel  (iss_sel),
        .rd_sel_a (rd_sel_a),
        .rd_sel_b (rd_sel_b),
        .regs     (regs),
        .busy     (busy),
        .hazard_a (hazard_a),
        .hazard_b (hazard_b)
    );

    // Model: clear-on-writeback then set-on-issue, so issue wins; register 31 never changes.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 32; r++) m_regs[r] <= '0;
            m_busy <= '0;
        end else begin
            if (wr_en && wr_sel != 5'd31) m_regs[wr_sel] <= wr_data;
            if (wr_en) m_busy[wr_sel] <= 1'b0;
            if (iss_en && iss_sel != 5'd31) m_busy[iss_sel] <= 1'b1;
        end
    end

    function automatic logic exp_haz(input logic [4:0] sel);
        logic h;
        h = m_busy[sel];
`ifdef REGSTORE_BYPASS_EN
        if (wr_en && wr_sel == sel && !(iss_en && iss_sel == sel)) h = 1'b0;
`endif
        return h;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] ws, input logic [31:0] wd,
                         input logic ie, input logic [4:0] is, input logic [4:0] ra,
                         input logic [4:0] rb);
        @(negedge clk);
        #1;
        wr_en = we; wr_sel = ws; wr_data = wd;
        iss_en = ie; iss_sel = is; rd_sel_a = ra; rd_sel_b = rb;
        #1;
    endtask

    task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, ra, rb);
    endtask

    initial begin
        logic [31:0] exp_byp;
        exp_byp = 32'd1;
`ifdef REGSTORE_BYPASS_EN
        exp_byp = 32'd0;
`endif
        @(posedge clk);
        #1;
        // Per-cycle comparison against the model on every falling edge.
        fork
            forever begin
                int bad;
                @(negedge clk);
                bad = 0;
                for (int r = 31; r >= 0; r--) if (regs[r] !== m_regs[r]) bad = r;
                chk($sformatf("cyc regs[%0d]", bad), regs[bad], m_regs[bad]);
                chk("cyc busy", busy, m_busy);
                chk("cyc hazard_a", 32'(hazard_a), 32'(exp_haz(rd_sel_a)));
                chk("cyc hazard_b", 32'(hazard_b), 32'(exp_haz(rd_sel_b)));
            end
        join_none

        idle(5'd0, 5'd0);
        chk("reset busy", busy, 32'h0);
        chk("reset regs[0]", regs[0], 32'h0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        idle(5'd0, 5'd0);

        // Sweep every storable register with a distinct pattern.
        for (int i = 0; i < 31; i++) drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        for (int i = 0; i < 31; i++) chk($sformatf("sweep regs[%0d]", i), regs[i], 32'(i) * 32'h01010101);
        chk("sweep regs[31]", regs[31], 32'h0);
        chk("sweep regs[30]", regs[30], 32'h1E1E1E1E);

        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        chk("basic regs[5]", regs[5], 32'hDEADBEEF);
        chk("basic regs[4]", regs[4], 32'h04040404);
        chk("basic regs[6]", regs[6], 32'h06060606);

        drive(1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 5'd31, 5'd31);
        idle(5'd31, 5'd31);
        chk("zero regs[31]", regs[31], 32'h0);
        chk("zero busy[31]", 32'(busy[31]), 32'h0);
        chk("zero hazard_a", 32'(hazard_a), 32'h0);

        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0);
        idle(5'd7, 5'd0);
        chk("sb hazard_a issued", 32'(hazard_a), 32'h1);
        drive(1'b1, 5'd7, 32'h12, 1'b0, 5'd0, 5'd7, 5'd0);
        chk("sb hazard_a wb cycle", 32'(hazard_a), exp_byp);
        idle(5'd7, 5'd0);
        chk("sb busy[7]", 32'(busy[7]), 32'h0);
        chk("sb regs[7]", regs[7], 32'h12);
        chk("sb hazard_a after", 32'(hazard_a), 32'h0);

        drive(1'b1, 5'd9, 32'hA5A55A5A, 1'b1, 5'd9, 5'd0, 5'd9);
        chk("sim hazard_b wb cycle", 32'(hazard_b), 32'h0);
        idle(5'd0, 5'd9);
        chk("sim regs[9]", regs[9], 32'hA5A55A5A);
        chk("sim busy[9]", 32'(busy[9]), 32'h1);
        chk("sim hazard_b", 32'(hazard_b), 32'h1);
        drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 5'd0, 5'd9);
        chk("sim hazard_b held", 32'(hazard_b), 32'h1);
        drive(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 5'd0, 5'd9);
        idle(5'd0, 5'd9);
        chk("sim busy[9] cleared", 32'(busy[9]), 32'h0);
        chk("sim regs[9] final", regs[9], 32'h2);

        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd3);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd3);
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd0, 5'd3);
        idle(5'd0, 5'd3);
        chk("reissue busy[3]", 32'(busy[3]), 32'h0);
        chk("reissue regs[3]", regs[3], 32'h33);

        drive(1'b1, 5'd12, 32'h00C0FFEE, 1'b0, 5'd0, 5'd12, 5'd0);
        idle(5'd12, 5'd0);
        chk("nonbusy busy[12]", 32'(busy[12]), 32'h0);
        chk("nonbusy regs[12]", regs[12], 32'h00C0FFEE);

        for (int k = 0; k < 60; k++)
            drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom),
                  5'($urandom), 5'($urandom));

        // Asynchronous reset mid-operation with a write and a claim in flight.
        drive(1'b1, 5'd4, 32'h44444444, 1'b0, 5'd0, 5'd20, 5'd4);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 5'd20, 5'd4);
        drive(1'b1, 5'd4, 32'hCAFEF00D, 1'b1, 5'd21, 5'd20, 5'd4);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 31; i++) chk($sformatf("async regs[%0d]", i), regs[i], 32'h0);
        chk("async busy", busy, 32'h0);
        chk("async hazard_a", 32'(hazard_a), 32'h0);
        @(posedge clk);
        #1;
        chk("reset-edge regs[4]", regs[4], 32'h0);
        chk("reset-edge busy", busy, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        reset_n = 1'b1;
        drive(1'b1, 5'd4, 32'h00000044, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        chk("post-reset regs[4]", regs[4], 32'h00000044);
        idle(5'd0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
